demo_sequencer: RTL

- Playback controller that sits directly upstream of the demo decoder.
- Owns the demo ROM address, tempo timing, play/stop/pause/loop control and ROM read latency.
- Presents a registered 96-bit song word: 6 voices x 16 bits, each voice = pitch[15:4], vol[3:2], wave[1:0].
- Outputs silence (all-zero word) whenever not playing, so downstream channels are disabled.

---
 rtl/demo_pkg.sv | 17 +
 rtl/demo_sequencer_if.sv | 34 +++
 rtl/tempo_counter.sv | 26 ++
 rtl/demo_sequencer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/demo_pkg.sv
// Shared types and constants for the demo playback path.
// Song word: 6 voices x {pitch[15:4], vol[3:2], wave[1:0]}.
package demo_pkg;

  localparam int DEMO_WORD_W = 96;
  localparam int VOICE_W     = 16;
  localparam int NUM_VOICES  = 6;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } seq_state_t;

  localparam logic [DEMO_WORD_W-1:0] SILENCE_WORD = '0;

endpackage

// File: rtl/demo_sequencer_if.sv
// ROM read port and decoder-facing song word bundle.
// master = sequencer, slave = ROM/decoder side.
interface demo_sequencer_if
  import demo_pkg::*;
#(
  parameter int AW = 7
) ();

  logic [AW-1:0]          rom_addr;
  logic [DEMO_WORD_W-1:0] rom_data;
  logic [DEMO_WORD_W-1:0] demo_data;
  logic                   demo_valid;
  logic                   playing;
  logic                   song_done;

  modport master (
    output rom_addr,
    input  rom_data,
    output demo_data,
    output demo_valid,
    output playing,
    output song_done
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  demo_data,
    input  demo_valid,
    input  playing,
    input  song_done
  );

endinterface

// File: rtl/tempo_counter.sv
// Loadable step-hold down-counter with freeze.
// Saturates at zero; zero flag is combinational.
module tempo_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        en,
  output logic        zero
);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 16'd1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/demo_sequencer.sv
// Demo playback controller: walks the song ROM at the
// programmed tempo and presents a registered song word.
module demo_sequencer
  import demo_pkg::*;
#(
  parameter int DEMO_SONG_LENGTH = 128,
  parameter int DEMO_CLK_DIVIDE  = 100,
  parameter int ROM_LATENCY      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  loop_en,
  input  logic [15:0]           tempo_div,
  demo_sequencer_if.master      bus
);

  localparam int AW = $clog2(DEMO_SONG_LENGTH);

  seq_state_t state;
  seq_state_t nxt;

  logic [1:0]             fetch_cnt;
  logic [1:0]             fetch_cnt_nxt;
  logic [AW-1:0]          addr_nxt;
  logic [DEMO_WORD_W-1:0] data_nxt;
  logic                   valid_nxt;
  logic                   done_nxt;

  logic        fetch_last;
  logic        last_addr;
  logic        hold_zero;
  logic        hold_en;
  logic        step_end;
  logic        capture;
  logic [15:0] tempo_eff;

  assign fetch_last = (fetch_cnt == 2'(ROM_LATENCY - 1));
  assign last_addr  = (bus.rom_addr == AW'(DEMO_SONG_LENGTH - 1));
  assign hold_en    = (state == HOLD) && !pause;
  assign step_end   = hold_en && hold_zero;
  assign capture    = (state == FETCH) && fetch_last
                      && !stop && !start;
  assign tempo_eff  = (tempo_div == '0)
                      ? 16'(DEMO_CLK_DIVIDE) : tempo_div;

  tempo_counter u_tempo (
    .clk      (clk),
    .rst      (rst),
    .load     (capture),
    .load_val (tempo_eff - 16'd1),
    .en       (hold_en),
    .zero     (hold_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      fetch_cnt      <= '0;
      bus.rom_addr   <= '0;
      bus.demo_data  <= SILENCE_WORD;
      bus.demo_valid <= 1'b0;
      bus.song_done  <= 1'b0;
    end else begin
      state          <= nxt;
      fetch_cnt      <= fetch_cnt_nxt;
      bus.rom_addr   <= addr_nxt;
      bus.demo_data  <= data_nxt;
      bus.demo_valid <= valid_nxt;
      bus.song_done  <= done_nxt;
    end
  end

  // stop outranks start; both outrank normal sequencing
  always_comb begin
    nxt = state;
    if (stop) begin
      nxt = IDLE;
    end else if (start) begin
      nxt = FETCH;
    end else begin
      unique case (state)
        FETCH: if (fetch_last) nxt = HOLD;
        HOLD: begin
          if (step_end) begin
            nxt = (!last_addr || loop_en) ? FETCH : IDLE;
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    addr_nxt      = bus.rom_addr;
    data_nxt      = bus.demo_data;
    valid_nxt     = capture;
    done_nxt      = 1'b0;
    fetch_cnt_nxt = '0;
    if (stop) begin
      addr_nxt = '0;
      data_nxt = SILENCE_WORD;
    end else if (start) begin
      addr_nxt = '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (capture) data_nxt = bus.rom_data;
          else fetch_cnt_nxt = fetch_cnt + 2'd1;
        end
        HOLD: begin
          if (step_end) begin
            done_nxt = last_addr;
            addr_nxt = last_addr ? '0 : bus.rom_addr + AW'(1);
            if (last_addr && !loop_en) data_nxt = SILENCE_WORD;
          end
        end
        default: ;
      endcase
    end
    bus.playing = (state != IDLE);
  end

endmodule
